// File: rtl/sfi_req_queue.sv
// Request queue behind the SFI address-check stage. Good words are buffered in a FWFT FIFO.
// All-zero (rejected) words are dropped and counted. A run of rejections locks the input.
module sfi_req_queue #(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned FAULT_LIMIT = 3,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_word,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_word,
    output logic             o_fault,
    output logic [CNT_W-1:0] o_fault_cnt,
    output logic             o_locked,
    input  logic             i_clear
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(FAULT_LIMIT + 1);

    typedef enum logic [0:0] {StRun, StLocked} state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic [CW-1:0]    r_consec;
    logic [CW-1:0]    w_consec_nxt;
    logic [CW-1:0]    w_consec_inc;
    logic             r_fault;
    logic [CNT_W-1:0] r_fault_cnt;

    logic w_full;
    logic w_empty;
    logic w_accept;
    logic w_push;
    logic w_reject;
    logic w_pop;

    assign w_full       = (r_count == (AW + 1)'(DEPTH));
    assign w_empty      = (r_count == '0);
    assign o_in_ready   = (r_state == StRun) && !w_full && !i_rst;
    assign w_accept     = i_in_valid && o_in_ready;
    assign w_push       = w_accept && (i_in_word != '0);
    assign w_reject     = w_accept && (i_in_word == '0);
    assign o_out_valid  = !w_empty;
    assign w_pop        = o_out_valid && i_out_ready;
    assign o_out_word   = w_empty ? '0 : r_mem[r_rptr];
    assign o_fault      = r_fault;
    assign o_fault_cnt  = r_fault_cnt;
    assign o_locked     = (r_state == StLocked);
    assign w_consec_inc = r_consec + 1'b1;

    // clear beats a coincident rejection: it zeroes the run and prevents the lock.
    always_comb begin
        w_state_nxt  = r_state;
        w_consec_nxt = r_consec;
        if (w_push) begin
            w_consec_nxt = '0;
        end else if (w_reject) begin
            w_consec_nxt = w_consec_inc;
            if (w_consec_inc == CW'(FAULT_LIMIT)) begin
                w_state_nxt = StLocked;
            end
        end
        if (i_clear) begin
            w_consec_nxt = '0;
            w_state_nxt  = StRun;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= StRun;
            r_consec <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_consec <= w_consec_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fault     <= 1'b0;
            r_fault_cnt <= '0;
        end else begin
            r_fault <= w_reject;
            if (w_reject && (r_fault_cnt != '1)) begin
                r_fault_cnt <= r_fault_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage needs no reset; o_out_word is masked while empty.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_in_word;
        end
    end

endmodule
